// File: rtl/jt49_pkg.sv
// rtl/jt49_pkg.sv - shared constants and helpers for the jt49 period divider
// Default sizing plus the zero-to-one effective period mapping.
package jt49_pkg;

   localparam int JT49_DIV_W  = 12;
   localparam int JT49_DIV_CH = 3;

   // A zero period behaves as one so a channel can never stall.
   function automatic logic [31:0] jt49_eff_period(input logic [31:0] p);
      return (p == 32'd0) ? 32'd1 : p;
   endfunction

endpackage

// File: rtl/jt49_div_multi_if.sv
// rtl/jt49_div_multi_if.sv - divider bus between register bank and generators
// Master drives enable/periods/restarts; slave returns square outputs and ticks.
interface jt49_div_multi_if
   import jt49_pkg::*;
#(
   parameter int W  = JT49_DIV_W,
   parameter int CH = JT49_DIV_CH
);
   logic            cen;
   logic [CH*W-1:0] period;
   logic [CH-1:0]   restart;
   logic [CH-1:0]   div;
   logic [CH-1:0]   tick;

   modport master (output cen, period, restart, input div, tick);
   modport slave  (input cen, period, restart, output div, tick);
endinterface

// File: rtl/jt49_div_ch.sv
// rtl/jt49_div_ch.sv - single divider channel: count, square output, tick strobe
// JT49_DIV_SHADOW_EN adds a shadow period reloaded only at safe points.
module jt49_div_ch
   import jt49_pkg::*;
#(
   parameter int W = JT49_DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_cen,
   input  logic [W-1:0] i_period,
   input  logic         i_restart,
   output logic         o_div,
   output logic         o_tick
);

   logic [W-1:0] r_count;
   logic         r_div;
   logic         r_tick;
   logic [W-1:0] w_src;
   logic [W-1:0] w_eff;
   logic         w_tc;

`ifdef JT49_DIV_SHADOW_EN
   logic [W-1:0] r_shadow;

   // An unloaded (zero) shadow defers to the live period until it captures it.
   assign w_src = (r_shadow == '0) ? i_period : r_shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else if (i_restart || (i_cen && (w_tc || r_shadow == '0))) begin
         r_shadow <= i_period;
      end
   end
`else
   assign w_src = i_period;
`endif

   assign w_eff = W'(jt49_eff_period(32'(w_src)));
   assign w_tc  = i_cen && (r_count >= w_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= W'(1);
         r_div   <= 1'b0;
         r_tick  <= 1'b0;
      end else if (i_restart) begin
         r_count <= W'(1);
         r_div   <= 1'b0;
         r_tick  <= 1'b0;
      end else if (w_tc) begin
         r_count <= W'(1);
         r_div   <= ~r_div;
         r_tick  <= 1'b1;
      end else if (i_cen) begin
         r_count <= r_count + W'(1);
         r_tick  <= 1'b0;
      end else begin
         r_tick  <= 1'b0;
      end
   end

   assign o_div  = r_div;
   assign o_tick = r_tick;

endmodule

// File: rtl/jt49_div_multi.sv
// rtl/jt49_div_multi.sv - CH-channel square-wave period divider for the PSG
// Optional shadow periods selected by JT49_DIV_SHADOW_EN.
module jt49_div_multi
   import jt49_pkg::*;
#(
   parameter int W  = JT49_DIV_W,
   parameter int CH = JT49_DIV_CH
) (
   input  logic             clk,
   input  logic             rst_n,
   jt49_div_multi_if.slave  bus
);

   logic [CH-1:0] w_div;
   logic [CH-1:0] w_tick;

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      jt49_div_ch #(.W(W)) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_cen     (bus.cen),
         .i_period  (bus.period[gi*W +: W]),
         .i_restart (bus.restart[gi]),
         .o_div     (w_div[gi]),
         .o_tick    (w_tick[gi])
      );
   end

   assign bus.div  = w_div;
   assign bus.tick = w_tick;

endmodule
